// File: rtl/msg_packer.sv
// msg_packer: packs [count][len][data]... messages densely into 64-bit AXI-Stream beats (option: MSG_PACKER_STATS_EN).
// First beat valid 3 cycles after the first accept; beats held under m_tready=0, msg_ready drops while the accumulator is full.
module msg_packer #(
  parameter int TDATA_WIDTH   = 64,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [15:0]                msg_length,
  input  logic [MAX_MSG_BYTES*8-1:0] msg_data,
  input  logic [15:0]                msg_count,
  input  logic                       msg_last,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [TDATA_WIDTH-1:0]     m_tdata,
  output logic [TDATA_WIDTH/8-1:0]   m_tkeep,
  output logic                       m_tlast,
`ifdef MSG_PACKER_STATS_EN
  output logic [31:0]                stat_pkts,
  output logic [31:0]                stat_errs,
`endif
  output logic                       m_tuser
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_MSG_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_FLUSH} state_t;

  typedef struct packed {
    logic [15:0]                len;
    logic [MAX_MSG_BYTES*8-1:0] data;
    logic                       last;
    logic                       bad;
  } msg_t;

  state_t       state;
  msg_t         cur;
  logic [15:0]  cnt_q;
  logic [16:0]  nmsg_q;
  logic [5:0]   sent_q;
  logic         err_q;
  logic [127:0] acc_q;
  logic [4:0]   fill_q;

  logic [5:0]   rem;
  logic [3:0]   want_n;
  logic [3:0]   app_n;
  logic [63:0]  src;
  logic [63:0]  app_mask;
  logic [127:0] acc_cat;
  logic [127:0] acc_nx;
  logic [4:0]   fill_cat;
  logic [4:0]   fill_nx;
  logic         can_append;
  logic         advance;
  logic         done;
  logic         out_free;
  logic         emit_full;
  logic         emit_last;
  logic         accept;
  logic         tlast_hs;
  logic         len_bad;
  logic         cnt_err;
  logic [16:0]  nmsg_inc;
  logic [15:0]  cnt_sel;

  assign rem = cur.bad ? 6'd0 : (cur.len[5:0] - sent_q);

  always_comb begin
    want_n = 4'd0;
    src    = 64'd0;
    case (state)
      S_HDR: begin
        want_n = 4'd2;
        src    = {48'd0, cnt_q};
      end
      S_LEN: begin
        want_n = cur.bad ? 4'd0 : 4'd2;
        src    = {48'd0, cur.len};
      end
      S_DATA: begin
        want_n = (rem > 6'd8) ? 4'd8 : rem[3:0];
        src    = 64'(cur.data >> {sent_q, 3'b000});
      end
      default: ;
    endcase
  end

  // New bytes land directly above the current fill, so a beat can leave in the same cycle they arrive.
  assign can_append = (fill_q <= 5'd8);
  assign app_n      = can_append ? want_n : 4'd0;
  assign app_mask   = (app_n == 4'd8) ? '1 : ((64'd1 << {app_n, 3'b000}) - 64'd1);
  assign acc_cat    = acc_q | ({64'd0, src & app_mask} << {fill_q, 3'b000});
  assign fill_cat   = fill_q + {1'b0, app_n};
  assign advance    = (app_n == want_n);
  assign done       = (state == S_DATA) && advance && (rem <= 6'd8);

  // Full beats leave only while more than 8 bytes are held, so FLUSH always keeps 1..8 bytes for the tlast beat.
  assign out_free  = !m_tvalid || m_tready;
  assign emit_full = out_free && (fill_cat > 5'd8);
  assign emit_last = out_free && (state == S_FLUSH) && (fill_cat != 5'd0) && (fill_cat <= 5'd8);

  assign msg_ready = (state == S_IDLE) || (done && !cur.last);
  assign accept    = msg_valid && msg_ready;
  assign tlast_hs  = m_tvalid && m_tready && m_tlast;

  assign nmsg_inc = (state == S_IDLE) ? 17'd1 : ((nmsg_q == '1) ? nmsg_q : nmsg_q + 17'd1);
  assign cnt_sel  = (state == S_IDLE) ? msg_count : cnt_q;
  assign len_bad  = (msg_length < MIN_LEN) || (msg_length > MAX_LEN);
  assign cnt_err  = msg_last && (nmsg_inc != {1'b0, cnt_sel});

  always_comb begin
    acc_nx  = acc_cat;
    fill_nx = fill_cat;
    if (emit_full) begin
      acc_nx  = {64'd0, acc_cat[127:64]};
      fill_nx = fill_cat - 5'd8;
    end else if (emit_last) begin
      acc_nx  = 128'd0;
      fill_nx = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= 128'd0;
      fill_q <= 5'd0;
    end else begin
      acc_q  <= acc_nx;
      fill_q <= fill_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (emit_full || emit_last) begin
      m_tvalid <= 1'b1;
      m_tdata  <= acc_cat[63:0];
      m_tkeep  <= emit_full ? 8'hFF : (8'hFF >> (4'd8 - fill_cat[3:0]));
      m_tlast  <= emit_last;
      m_tuser  <= emit_last && err_q;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cur    <= '0;
      cnt_q  <= 16'd0;
      nmsg_q <= 17'd0;
      sent_q <= 6'd0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        cur.len  <= msg_length;
        cur.data <= msg_data;
        cur.last <= msg_last;
        cur.bad  <= len_bad;
        nmsg_q   <= nmsg_inc;
        sent_q   <= 6'd0;
        if (len_bad || cnt_err) err_q <= 1'b1;
      end else if (state == S_DATA && advance) begin
        sent_q <= sent_q + {2'b00, app_n};
      end
      case (state)
        S_IDLE: if (accept) begin
          cnt_q <= msg_count;
          state <= S_HDR;
        end
        S_HDR: if (advance) state <= S_LEN;
        S_LEN: if (advance) state <= S_DATA;
        // A finished non-last message with no successor parks here with rem = 0.
        S_DATA: if (done) begin
          if (cur.last)       state <= S_FLUSH;
          else if (msg_valid) state <= S_LEN;
        end
        S_FLUSH: if (tlast_hs) begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MSG_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts <= 32'd0;
      stat_errs <= 32'd0;
    end else if (tlast_hs) begin
      if (stat_pkts != '1)            stat_pkts <= stat_pkts + 32'd1;
      if (m_tuser && stat_errs != '1) stat_errs <= stat_errs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msg_packer.sv
// Directed bench for msg_packer: beats captured on handshakes and checked against hand-computed wire images.
`timescale 1ns/1ps
module tb_msg_packer;

  logic         tb_clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [15:0]  msg_length = 16'd0;
  logic [255:0] msg_data = '0;
  logic [15:0]  msg_count = 16'd0;
  logic         msg_last = 1'b0;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tlast;
  logic         m_tuser;
`ifdef MSG_PACKER_STATS_EN
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_errs;
`endif

  always #5 tb_clk = ~tb_clk;

  msg_packer dut (
    .clk        (tb_clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_length (msg_length),
    .msg_data   (msg_data),
    .msg_count  (msg_count),
    .msg_last   (msg_last),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tlast    (m_tlast),
`ifdef MSG_PACKER_STATS_EN
    .stat_pkts  (stat_pkts),
    .stat_errs  (stat_errs),
`endif
    .m_tuser    (m_tuser)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t rx_q[$];
  beat_t prev;
  logic  prev_stall = 1'b0;
  logic  tog_en = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    tlast_cnt = 0;

  localparam logic [255:0] D_A = 256'hffff_a5b0_0388_9560_8413_0858_045d_e506;
  localparam logic [255:0] D_B = 256'hd845a30c_85468052;
  localparam logic [255:0] D_1 = 256'h630d658d_abcddcef;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture every handshake and verify the beat stays frozen while stalled.
  always @(negedge tb_clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {63'd0, m_tvalid}, 64'd1);
        chk("stall_data", m_tdata, prev.d);
        chk("stall_ctl", {54'd0, m_tkeep, m_tlast, m_tuser}, {54'd0, prev.k, prev.l, prev.u});
      end
      if (m_tvalid && m_tready) begin
        rx_q.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast, u: m_tuser});
        if (m_tlast) tlast_cnt++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev = '{d: m_tdata, k: m_tkeep, l: m_tlast, u: m_tuser};
    end
  end

  task automatic send(input logic [15:0] cnt, input logic [15:0] len, input logic [255:0] data,
                      input logic last);
    logic got = 1'b0;
    int   n = 0;
    msg_count  = cnt;
    msg_length = len;
    msg_data   = data;
    msg_last   = last;
    msg_valid  = 1'b1;
    while (!got && n < 200) begin
      @(negedge tb_clk);
      if (msg_ready) got = 1'b1;
      n++;
    end
    chk("msg_accept", {63'd0, got}, 64'd1);
    @(posedge tb_clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int target);
    int k = 0;
    while (tlast_cnt < target && k < 500) begin
      @(posedge tb_clk);
      k++;
    end
    chk("pkt_done", {63'd0, tlast_cnt >= target}, 64'd1);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic u);
    beat_t b;
    if (rx_q.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      b = rx_q.pop_front();
      chk({tag, "_data"}, b.d, d);
      chk({tag, "_ctl"}, {54'd0, b.k, b.l, b.u}, {54'd0, k, l, u});
    end
  endtask

  task automatic expect_t1(input string tag);
    expect_beat({tag, "_b0"}, 64'habcddcef_00080001, 8'hFF, 1'b0, 1'b0);
    expect_beat({tag, "_b1"}, 64'h00000000_630d658d, 8'h0F, 1'b1, 1'b0);
    chk({tag, "_extra"}, 64'(rx_q.size()), 64'd0);
  endtask

  task automatic expect_t2(input string tag);
    expect_beat({tag, "_b0"}, 64'h045de506_000e0002, 8'hFF, 1'b0, 1'b0);
    expect_beat({tag, "_b1"}, 64'h03889560_84130858, 8'hFF, 1'b0, 1'b0);
    expect_beat({tag, "_b2"}, 64'h85468052_0008a5b0, 8'hFF, 1'b0, 1'b0);
    expect_beat({tag, "_b3"}, 64'h00000000_d845a30c, 8'h0F, 1'b1, 1'b0);
    chk({tag, "_extra"}, 64'(rx_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int k;
    int pk;
    fork
      forever begin
        @(posedge tb_clk);
        #1;
        if (tog_en) m_tready = ~m_tready;
      end
    join_none

    // Reset values
    repeat (2) @(posedge tb_clk);
    #2;
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_ctl", {54'd0, m_tkeep, m_tlast, m_tuser}, 64'd0);
    chk("rst_ready", {63'd0, msg_ready}, 64'd1);
    rst = 1'b0;
    @(posedge tb_clk);
    #1;

    // T1: single message, first-beat latency and ready drop
    send(16'd1, 16'd8, D_1, 1'b1);
    chk("t1_ready_low", {63'd0, msg_ready}, 64'd0);
    lat = 0;
    while (!m_tvalid && lat < 10) begin
      @(posedge tb_clk);
      #1;
      lat++;
    end
    chk("t1_latency_le3", {63'd0, lat <= 3}, 64'd1);
    wait_pkts(1);
    expect_t1("t1");

    // T2: two messages straddling beats
    send(16'd2, 16'd14, D_A, 1'b0);
    send(16'd2, 16'd8, D_B, 1'b1);
    wait_pkts(2);
    expect_t2("t2");

    // T3: T2 under alternating m_tready
    tog_en = 1'b1;
    send(16'd2, 16'd14, D_A, 1'b0);
    send(16'd2, 16'd8, D_B, 1'b1);
    wait_pkts(3);
    tog_en = 1'b0;
    m_tready = 1'b1;
    expect_t2("t3");

    // T4: undersized message dropped, error flagged on tlast
    send(16'd2, 16'd4, 256'hdeadbeef, 1'b0);
    send(16'd2, 16'd8, 256'h88776655_44332211, 1'b1);
    wait_pkts(4);
    expect_beat("t4_b0", 64'h44332211_00080002, 8'hFF, 1'b0, 1'b0);
    expect_beat("t4_b1", 64'h00000000_88776655, 8'h0F, 1'b1, 1'b1);
    chk("t4_extra", 64'(rx_q.size()), 64'd0);

    // T5: count mismatch, then a clean packet must not inherit the error
    send(16'd3, 16'd8, 256'h07060504_03020100, 1'b0);
    send(16'd3, 16'd8, 256'h0f0e0d0c_0b0a0908, 1'b1);
    wait_pkts(5);
    expect_beat("t5_b0", 64'h03020100_00080003, 8'hFF, 1'b0, 1'b0);
    expect_beat("t5_b1", 64'h09080008_07060504, 8'hFF, 1'b0, 1'b0);
    expect_beat("t5_b2", 64'h00000f0e_0d0c0b0a, 8'h3F, 1'b1, 1'b1);
    send(16'd1, 16'd8, D_1, 1'b1);
    wait_pkts(6);
    expect_t1("t5_next");

    // T6: reset with beat 3 of T2 stalled on the output
    send(16'd2, 16'd14, D_A, 1'b0);
    k = 0;
    while (rx_q.size() < 2 && k < 100) begin
      @(negedge tb_clk);
      k++;
    end
    @(posedge tb_clk);
    #1;
    m_tready = 1'b0;
    send(16'd2, 16'd8, D_B, 1'b1);
    repeat (4) @(posedge tb_clk);
    #1;
    chk("t6_pre_valid", {63'd0, m_tvalid}, 64'd1);
    pk = tlast_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'd0, m_tvalid}, 64'd0);
    @(posedge tb_clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_post_ready", {63'd0, msg_ready}, 64'd1);
    chk("t6_post_ctl", {62'd0, m_tvalid, m_tlast}, 64'd0);
    chk("t6_no_tlast", 64'(tlast_cnt), 64'(pk));
    expect_beat("t6_b0", 64'h045de506_000e0002, 8'hFF, 1'b0, 1'b0);
    expect_beat("t6_b1", 64'h03889560_84130858, 8'hFF, 1'b0, 1'b0);
    chk("t6_partial", 64'(rx_q.size()), 64'd0);
    m_tready = 1'b1;
    @(posedge tb_clk);
    #1;
    send(16'd1, 16'd8, D_1, 1'b1);
    wait_pkts(pk + 1);
    expect_t1("t6_after");
`ifdef MSG_PACKER_STATS_EN
    chk("stat_pkts", {32'd0, stat_pkts}, 64'd1);
    chk("stat_errs", {32'd0, stat_errs}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
